// File: rtl/dcnn_pkg.sv
// Shared CNN accelerator definitions: score word width and signed score type.
package dcnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] score_t;

endpackage

// File: rtl/fc_argmax_if.sv
// Score stream in, held classification result out, both valid/ready.
interface fc_argmax_if
    import dcnn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int idxWidth  = 4
);

    logic                 inValid;
    logic                 inReady;
    logic [dataWidth-1:0] inData;
    logic                 outValid;
    logic                 outReady;
    logic [idxWidth-1:0]  classIdx;
    logic [dataWidth-1:0] maxValue;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, classIdx, maxValue
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, classIdx, maxValue
    );

endinterface

// File: rtl/fc_argmax.sv
// Running signed argmax over one inference of FC output scores;
// the winning index and score are held until the consumer takes them.
module fc_argmax
    import dcnn_pkg::*;
#(
    parameter int numClasses = 10,
    parameter int dataWidth  = DATA_WIDTH,
    localparam int idxWidth  = (numClasses > 1) ? $clog2(numClasses) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    fc_argmax_if.slave  bus,
    output logic        busy,
    output logic        finished
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [idxWidth-1:0] LAST = idxWidth'(numClasses - 1);

    logic [1:0]                  r_state;
    logic [idxWidth-1:0]         r_count;
    logic [idxWidth-1:0]         r_idx;
    logic signed [dataWidth-1:0] r_max;
    logic                        r_fin;

    logic                        w_xfer;
    logic                        w_take;
    logic signed [dataWidth-1:0] w_score;

    assign w_score = $signed(bus.inData);
    assign w_xfer  = (r_state == S_ACCUM) && bus.inValid;
    // Strict greater-than keeps the lowest index on ties
    assign w_take  = (r_count == '0) || (w_score > r_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_max   <= '0;
            r_fin   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_count <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        if (w_take) begin
                            r_max <= w_score;
                            r_idx <= r_count;
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST)
                            r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.outReady) begin
                        r_state <= S_IDLE;
                        r_fin   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.inReady  = (r_state == S_ACCUM);
    assign bus.outValid = (r_state == S_HOLD);
    assign bus.classIdx = r_idx;
    assign bus.maxValue = r_max;
    assign busy         = (r_state != S_IDLE);
    assign finished     = r_fin;

endmodule
